mem_access: RTL



---
 rtl/mem_access_pkg.sv | 56 +++++
 rtl/mem_access_if.sv | 20 ++
 rtl/mem_access_load_align.sv | 26 ++
 rtl/mem_access.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared funct3 codes, FSM state encodings and strobe constants for the memory stage.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] MEM_ST_IDLE = 2'd0;
  localparam logic [1:0] MEM_ST_BUSY = 2'd1;
  localparam logic [1:0] MEM_ST_DONE = 2'd2;

  localparam logic [3:0] WSTRB_NONE = 4'b0000;
  localparam logic [3:0] WSTRB_B0   = 4'b0001;
  localparam logic [3:0] WSTRB_H_LO = 4'b0011;
  localparam logic [3:0] WSTRB_H_HI = 4'b1100;
  localparam logic [3:0] WSTRB_W    = 4'b1111;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Undefined funct3 codes fall back to a full word for both loads and stores.
  function automatic size_e access_size(input logic is_store, input logic [2:0] func);
    size_e sz;
    sz = SZ_WORD;
    if (is_store) begin
      case (func)
        F3_B:    sz = SZ_BYTE;
        F3_H:    sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (func)
        F3_B, F3_BU: sz = SZ_BYTE;
        F3_H, F3_HU: sz = SZ_HALF;
        default:     sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] offset);
    logic mis;
    case (sz)
      SZ_HALF: mis = offset[0];
      SZ_WORD: mis = (offset != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Single-outstanding req/ack data bus between the memory stage and data memory.
interface mem_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output ack, rdata
  );
endinterface

// File: rtl/mem_access_load_align.sv
// Combinational lane select and sign/zero extension of a raw load word.
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  func,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    case (func)
      F3_B:    result = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   result = {24'd0, byte_lane};
      F3_H:    result = {{16{half_lane[15]}}, half_lane};
      F3_HU:   result = {16'd0, half_lane};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rv32 memory stage: one outstanding bus access, stall while in flight, valM valid in DONE (3 cycles min).
// Optional MEM_MISALIGN_CHECK_EN flags misaligned accesses in IDLE instead of issuing them.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         regM_i_mem_rd,
  input  logic         regM_i_mem_wr,
  input  logic [2:0]   regM_i_mem_func,
  input  logic [31:0]  regM_i_valE,
  input  logic [31:0]  regM_i_valB,
  mem_access_if.master dbus,
  output logic [31:0]  memory_o_valM,
  output logic         memory_o_stall,
  output logic         memory_o_bus_err,
  output logic         memory_o_misalign
);

  localparam logic [8:0] TIMEOUT_LIM = TIMEOUT_CYCLES[8:0];

  logic [1:0]  state;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] load_buf;
  logic [7:0]  wait_cnt;
  logic        bus_err_q;
  logic [1:0]  ld_offset;
  logic [2:0]  ld_func;
  logic        ld_pending;

  logic        is_store;
  logic        access_req;
  logic        access;
  logic        misalign;
  size_e       size;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [8:0]  cnt_next;
  logic [31:0] aligned;

  // A store wins when both requests are raised together.
  assign is_store   = regM_i_mem_wr;
  assign access_req = regM_i_mem_rd | regM_i_mem_wr;
  assign size       = access_size(is_store, regM_i_mem_func);

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign = (state == MEM_ST_IDLE) && access_req &&
                    is_misaligned(size, regM_i_valE[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign access   = access_req & ~misalign;
  assign cnt_next = {1'b0, wait_cnt} + 9'd1;

  always_comb begin
    st_wdata = regM_i_valB;
    st_wstrb = WSTRB_W;
    case (size)
      SZ_BYTE: begin
        st_wdata = {4{regM_i_valB[7:0]}};
        st_wstrb = WSTRB_B0 << regM_i_valE[1:0];
      end
      SZ_HALF: begin
        st_wdata = {2{regM_i_valB[15:0]}};
        st_wstrb = regM_i_valE[1] ? WSTRB_H_HI : WSTRB_H_LO;
      end
      default: begin
        st_wdata = regM_i_valB;
        st_wstrb = WSTRB_W;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MEM_ST_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= WSTRB_NONE;
      load_buf   <= 32'd0;
      wait_cnt   <= 8'd0;
      bus_err_q  <= 1'b0;
      ld_offset  <= 2'd0;
      ld_func    <= 3'd0;
      ld_pending <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      case (state)
        MEM_ST_IDLE: begin
          if (access) begin
            state      <= MEM_ST_BUSY;
            req_q      <= 1'b1;
            we_q       <= is_store;
            addr_q     <= {regM_i_valE[31:2], 2'b00};
            wdata_q    <= is_store ? st_wdata : 32'd0;
            wstrb_q    <= is_store ? st_wstrb : WSTRB_NONE;
            wait_cnt   <= 8'd0;
            ld_offset  <= regM_i_valE[1:0];
            ld_func    <= regM_i_mem_func;
            ld_pending <= ~is_store;
          end
        end
        MEM_ST_BUSY: begin
          if (dbus.ack) begin
            load_buf <= dbus.rdata;
            req_q    <= 1'b0;
            state    <= MEM_ST_DONE;
          end else if (cnt_next == TIMEOUT_LIM) begin
            // Abandoned access: the pipeline still sees a (zero) result in DONE.
            load_buf  <= 32'd0;
            req_q     <= 1'b0;
            bus_err_q <= 1'b1;
            state     <= MEM_ST_DONE;
          end else begin
            wait_cnt <= cnt_next[7:0];
          end
        end
        MEM_ST_DONE: state <= MEM_ST_IDLE;
        default:     state <= MEM_ST_IDLE;
      endcase
    end
  end

  load_align u_load_align (
    .rdata  (load_buf),
    .offset (ld_offset),
    .func   (ld_func),
    .result (aligned)
  );

  assign dbus.req   = req_q;
  assign dbus.we    = we_q;
  assign dbus.addr  = addr_q;
  assign dbus.wdata = wdata_q;
  assign dbus.wstrb = wstrb_q;

  assign memory_o_valM     = ((state == MEM_ST_DONE) && ld_pending) ? aligned : 32'd0;
  assign memory_o_stall    = ((state == MEM_ST_IDLE) && access) || (state == MEM_ST_BUSY);
  assign memory_o_bus_err  = bus_err_q;
  assign memory_o_misalign = misalign;

endmodule
